// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO in front of a UART transmitter (8N1, LSB first).
// Bytes arrive as a one-cycle strobe and are framed onto tx_serial back to back.
// Optional macro UART_TX_PARITY_EN inserts an even-parity bit between data and stop.
module uart_tx_fifo #(
   parameter int unsigned CLKS_PER_BIT = 868,
   parameter int unsigned FIFO_DEPTH   = 16,
   parameter int unsigned CNT_W        = $clog2(FIFO_DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       tx_data,
   input  logic             tx_write,
   output logic             fifo_full,
   output logic [CNT_W-1:0] fifo_count,
   output logic             overflow,
   output logic             tx_busy,
   output logic             tx_serial
);

   localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

   state_t             r_state;
   logic [7:0]         r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   r_wptr;
   logic [PTR_W-1:0]   r_rptr;
   logic [CNT_W-1:0]   r_count;
   logic               r_overflow;
   logic [BAUD_W-1:0]  r_baud;
   logic [2:0]         r_bit;
   logic [7:0]         r_shift;
   logic               r_tx;
   logic               r_busy;
`ifdef UART_TX_PARITY_EN
   logic               r_parity;
`endif

   logic               w_full;
   logic               w_empty;
   logic               w_wr;
   logic               w_pop;
   logic               w_baud_end;
   logic [7:0]         w_head;

   assign w_full     = (r_count == CNT_W'(FIFO_DEPTH));
   assign w_empty    = (r_count == '0);
   assign w_wr       = tx_write && !w_full;
   assign w_baud_end = (r_baud == BAUD_W'(CLKS_PER_BIT - 1));
   // The head is popped when idle, or at the very end of a stop bit so frames abut.
   assign w_pop      = !w_empty && ((r_state == S_IDLE) || ((r_state == S_STOP) && w_baud_end));
   assign w_head     = r_mem[r_rptr];

   assign fifo_full  = w_full;
   assign fifo_count = r_count;
   assign overflow   = r_overflow;
   assign tx_busy    = r_busy;
   assign tx_serial  = r_tx;

   // Byte storage; contents need no reset since count gates every read.
   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_mem[r_wptr] <= tx_data;
      end
   end

   // FIFO pointers, occupancy and the dropped-write pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_overflow <= tx_write && w_full;
         if (w_wr) begin
            r_wptr <= r_wptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + PTR_W'(1);
         end
         case ({w_wr, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Transmit FSM; the line and busy flag are registered one cycle behind the state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_baud   <= '0;
         r_bit    <= '0;
         r_shift  <= '0;
         r_tx     <= 1'b1;
         r_busy   <= 1'b0;
`ifdef UART_TX_PARITY_EN
         r_parity <= 1'b0;
`endif
      end else begin
         r_busy <= (r_state != S_IDLE) || !w_empty;
         case (r_state)
            S_IDLE: begin
               r_tx   <= 1'b1;
               r_baud <= '0;
               r_bit  <= '0;
               if (w_pop) begin
                  r_shift  <= w_head;
`ifdef UART_TX_PARITY_EN
                  r_parity <= ^w_head;
`endif
                  r_state  <= S_START;
               end
            end
            S_START: begin
               r_tx <= 1'b0;
               if (w_baud_end) begin
                  r_baud  <= '0;
                  r_bit   <= '0;
                  r_state <= S_DATA;
               end else begin
                  r_baud <= r_baud + BAUD_W'(1);
               end
            end
            S_DATA: begin
               r_tx <= r_shift[0];
               if (w_baud_end) begin
                  r_baud  <= '0;
                  r_shift <= {1'b0, r_shift[7:1]};
                  r_bit   <= r_bit + 3'd1;
                  if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     r_state <= S_PARITY;
`else
                     r_state <= S_STOP;
`endif
                  end
               end else begin
                  r_baud <= r_baud + BAUD_W'(1);
               end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
               r_tx <= r_parity;
               if (w_baud_end) begin
                  r_baud  <= '0;
                  r_state <= S_STOP;
               end else begin
                  r_baud <= r_baud + BAUD_W'(1);
               end
            end
`endif
            S_STOP: begin
               r_tx <= 1'b1;
               if (w_baud_end) begin
                  r_baud <= '0;
                  if (w_pop) begin
                     r_shift  <= w_head;
`ifdef UART_TX_PARITY_EN
                     r_parity <= ^w_head;
`endif
                     r_state  <= S_START;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end else begin
                  r_baud <= r_baud + BAUD_W'(1);
               end
            end
            default: begin
               r_tx    <= 1'b1;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed bench for uart_tx_fifo at CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Build with UART_TX_PARITY_EN defined to exercise the parity frame.
module tb_uart_tx_fifo;

   localparam int unsigned CPB   = 4;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned CW    = 3;
`ifdef UART_TX_PARITY_EN
   localparam int unsigned NBITS = 11;
`else
   localparam int unsigned NBITS = 10;
`endif
   localparam int unsigned FRAME = NBITS * CPB;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [7:0]    tx_data = 8'h00;
   logic          tx_write = 1'b0;
   logic          fifo_full;
   logic [CW-1:0] fifo_count;
   logic          overflow;
   logic          tx_busy;
   logic          tx_serial;

   int n_checks = 0;
   int n_fail   = 0;

   uart_tx_fifo #(
      .CLKS_PER_BIT(CPB),
      .FIFO_DEPTH  (DEPTH),
      .CNT_W       (CW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .tx_data   (tx_data),
      .tx_write  (tx_write),
      .fifo_full (fifo_full),
      .fifo_count(fifo_count),
      .overflow  (overflow),
      .tx_busy   (tx_busy),
      .tx_serial (tx_serial)
   );

   always #5 clk = ~clk;

   // Decode one frame from the line, sampling mid-bit; ok drops on a framing error.
   task automatic rx_byte(output logic [7:0] b, output bit ok);
      int t;
      b  = 8'h00;
      ok = 1'b1;
      t  = 0;
      while (tx_serial !== 1'b0 && t < 4 * FRAME) begin
         @(negedge clk);
         t++;
      end
      if (tx_serial !== 1'b0) begin
         ok = 1'b0;
         return;
      end
      repeat (CPB / 2) @(negedge clk);
      if (tx_serial !== 1'b0) ok = 1'b0;
      for (int j = 0; j < 8; j++) begin
         repeat (CPB) @(negedge clk);
         b[j] = tx_serial;
      end
`ifdef UART_TX_PARITY_EN
      repeat (CPB) @(negedge clk);
      if (tx_serial !== ^b) ok = 1'b0;
`endif
      repeat (CPB) @(negedge clk);
      if (tx_serial !== 1'b1) ok = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_checks++;
      if ({tx_serial, fifo_full, fifo_count, overflow, tx_busy} !== {1'b1, 1'b0, 3'd0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_during: got ser=%b full=%b cnt=%0d ovf=%b busy=%b want 1 0 0 0 0",
                  tx_serial, fifo_full, fifo_count, overflow, tx_busy);
      end
      rst = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({tx_serial, fifo_full, fifo_count, overflow, tx_busy} !== {1'b1, 1'b0, 3'd0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_after: got ser=%b full=%b cnt=%0d ovf=%b busy=%b want 1 0 0 0 0",
                  tx_serial, fifo_full, fifo_count, overflow, tx_busy);
      end
   endtask

   task automatic test_single();
      logic          ln [FRAME + 6];
      logic          bz [FRAME + 6];
      logic [CW-1:0] cn [FRAME + 6];
      logic [NBITS-1:0] fr;
      logic e;
`ifdef UART_TX_PARITY_EN
      fr = {1'b1, 1'b0, 8'hA5, 1'b0};
`else
      fr = {1'b1, 8'hA5, 1'b0};
`endif
      @(negedge clk);
      tx_data  = 8'hA5;
      tx_write = 1'b1;
      for (int k = 0; k < FRAME + 6; k++) begin
         @(negedge clk);
         tx_write = 1'b0;
         ln[k] = tx_serial;
         bz[k] = tx_busy;
         cn[k] = fifo_count;
      end
      n_checks++;
      if (cn[0] !== 3'd1) begin
         n_fail++;
         $display("FAIL single_count0: got %0d want 1", cn[0]);
      end
      n_checks++;
      if (cn[1] !== 3'd0) begin
         n_fail++;
         $display("FAIL single_count1: got %0d want 0", cn[1]);
      end
      for (int k = 0; k < FRAME + 6; k++) begin
         e = (k < 2 || k >= FRAME + 2) ? 1'b1 : fr[(k - 2) / CPB];
         n_checks++;
         if (ln[k] !== e) begin
            n_fail++;
            $display("FAIL single_line cycle %0d: got %b want %b", k, ln[k], e);
         end
      end
      for (int k = 1; k < FRAME + 6; k++) begin
         e = (k <= FRAME + 1) ? 1'b1 : 1'b0;
         n_checks++;
         if (bz[k] !== e) begin
            n_fail++;
            $display("FAIL single_busy cycle %0d: got %b want %b", k, bz[k], e);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [2*NBITS-1:0] fr;
      logic e;
      logic got;
      int   peak;
`ifdef UART_TX_PARITY_EN
      fr = {1'b1, 1'b0, 8'h0F, 1'b0, 1'b1, 1'b0, 8'h55, 1'b0};
`else
      fr = {1'b1, 8'h0F, 1'b0, 1'b1, 8'h55, 1'b0};
`endif
      peak = 0;
      @(negedge clk);
      tx_data  = 8'h55;
      tx_write = 1'b1;
      for (int k = 0; k < 2 * FRAME + 6; k++) begin
         @(negedge clk);
         if (k == 0) tx_data = 8'h0F;
         else        tx_write = 1'b0;
         got = tx_serial;
         if (int'(fifo_count) > peak) peak = int'(fifo_count);
         e = (k < 2 || k >= 2 * FRAME + 2) ? 1'b1 : fr[(k - 2) / CPB];
         n_checks++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL b2b_line cycle %0d: got %b want %b", k, got, e);
         end
      end
      n_checks++;
      if (peak != 1) begin
         n_fail++;
         $display("FAIL b2b_peak_count: got %0d want 1", peak);
      end
   endtask

   task automatic test_overflow();
      logic          ov [8];
      logic          fu [8];
      logic [CW-1:0] cn [8];
      logic [7:0]    b;
      bit            ok;
      int            lows;
      @(negedge clk);
      fork
         begin
            tx_data  = 8'h01;
            tx_write = 1'b1;
            for (int k = 0; k < 8; k++) begin
               @(negedge clk);
               if (k < 5) tx_data = 8'(k + 2);
               else       tx_write = 1'b0;
               ov[k] = overflow;
               fu[k] = fifo_full;
               cn[k] = fifo_count;
            end
         end
         begin
            for (int i = 0; i < 5; i++) begin
               rx_byte(b, ok);
               n_checks++;
               if (!ok || b !== 8'(i + 1)) begin
                  n_fail++;
                  $display("FAIL ovf_rx byte %0d: got %h ok=%0d want %h ok=1", i, b, ok, 8'(i + 1));
               end
            end
         end
      join
      n_checks++;
      if (fu[3] !== 1'b0 || fu[4] !== 1'b1 || cn[4] !== 3'd4) begin
         n_fail++;
         $display("FAIL ovf_full: got full3=%b full4=%b cnt4=%0d want 0 1 4", fu[3], fu[4], cn[4]);
      end
      n_checks++;
      if ({ov[4], ov[5], ov[6]} !== 3'b010) begin
         n_fail++;
         $display("FAIL ovf_pulse: got %b%b%b want 010", ov[4], ov[5], ov[6]);
      end
      lows = 0;
      for (int k = 0; k < 2 * FRAME; k++) begin
         @(negedge clk);
         if (tx_serial !== 1'b1 || fifo_count !== 3'd0) lows++;
      end
      n_checks++;
      if (lows != 0) begin
         n_fail++;
         $display("FAIL ovf_quiet: got %0d non-idle cycles want 0", lows);
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] dat [3];
      int bad;
      dat[0] = 8'h11;
      dat[1] = 8'h22;
      dat[2] = 8'h33;
      @(negedge clk);
      tx_data  = 8'h00;
      tx_write = 1'b1;
      for (int k = 0; k <= 19; k++) begin
         @(negedge clk);
         if (k < 3) tx_data = dat[k];
         else       tx_write = 1'b0;
      end
      n_checks++;
      if (tx_serial !== 1'b0 || fifo_count !== 3'd3) begin
         n_fail++;
         $display("FAIL rstmid_before: got ser=%b cnt=%0d want 0 3", tx_serial, fifo_count);
      end
      rst = 1'b1;
      #1;
      n_checks++;
      if (tx_serial !== 1'b1 || fifo_count !== 3'd0 || fifo_full !== 1'b0 || tx_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_async: got ser=%b cnt=%0d full=%b busy=%b want 1 0 0 0",
                  tx_serial, fifo_count, fifo_full, tx_busy);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      bad = 0;
      for (int k = 0; k < 3 * FRAME; k++) begin
         @(negedge clk);
         if (tx_serial !== 1'b1 || fifo_count !== 3'd0) bad++;
      end
      n_checks++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL rstmid_quiet: got %0d non-idle cycles want 0", bad);
      end
   endtask

   task automatic test_wrap();
      logic [7:0] b;
      bit         ok;
      fork
         begin
            for (int i = 0; i < 2 * DEPTH + 3; i++) begin
               int t;
               t = 0;
               @(negedge clk);
               while (fifo_count >= 3'd2 && t < 4 * FRAME) begin
                  @(negedge clk);
                  t++;
               end
               n_checks++;
               if (t >= 4 * FRAME) begin
                  n_fail++;
                  $display("FAIL wrap_pace byte %0d: count stuck at %0d want below 2", i, fifo_count);
               end
               tx_data  = 8'(i);
               tx_write = 1'b1;
               @(negedge clk);
               tx_write = 1'b0;
            end
         end
         begin
            for (int i = 0; i < 2 * DEPTH + 3; i++) begin
               rx_byte(b, ok);
               n_checks++;
               if (!ok || b !== 8'(i)) begin
                  n_fail++;
                  $display("FAIL wrap_rx byte %0d: got %h ok=%0d want %h ok=1", i, b, ok, 8'(i));
               end
            end
         end
      join
      repeat (4) @(negedge clk);
      n_checks++;
      if (fifo_count !== 3'd0 || tx_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL wrap_drain: got cnt=%0d busy=%b want 0 0", fifo_count, tx_busy);
      end
   endtask

`ifdef UART_TX_PARITY_EN
   task automatic test_parity();
      logic [7:0] dat [2];
      logic       par [2];
      logic       ln [FRAME + 6];
      logic       bz [FRAME + 6];
      dat[0] = 8'h07; par[0] = 1'b1;
      dat[1] = 8'h03; par[1] = 1'b0;
      for (int n = 0; n < 2; n++) begin
         @(negedge clk);
         tx_data  = dat[n];
         tx_write = 1'b1;
         for (int k = 0; k < FRAME + 6; k++) begin
            @(negedge clk);
            tx_write = 1'b0;
            ln[k] = tx_serial;
            bz[k] = tx_busy;
         end
         n_checks++;
         if (ln[2 + 8 * CPB + 1] !== 1'b0) begin
            n_fail++;
            $display("FAIL parity_bit7 byte %h: got %b want 0", dat[n], ln[2 + 8 * CPB + 1]);
         end
         n_checks++;
         if (ln[2 + 9 * CPB + 1] !== par[n]) begin
            n_fail++;
            $display("FAIL parity_bit byte %h: got %b want %b", dat[n], ln[2 + 9 * CPB + 1], par[n]);
         end
         n_checks++;
         if (ln[2 + 10 * CPB + 1] !== 1'b1) begin
            n_fail++;
            $display("FAIL parity_stop byte %h: got %b want 1", dat[n], ln[2 + 10 * CPB + 1]);
         end
         n_checks++;
         if (bz[45] !== 1'b1 || bz[46] !== 1'b0) begin
            n_fail++;
            $display("FAIL parity_len byte %h: got busy45=%b busy46=%b want 1 0", dat[n], bz[45], bz[46]);
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_overflow();
      test_reset_mid();
      test_wrap();
`ifdef UART_TX_PARITY_EN
      test_parity();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
